// File: rtl/dsp_pipelined_mac.sv
`default_nettype none
// ============================================================================
// Module   : dsp_pipelined_mac
// Brief    : Pipelined unsigned multiply / multiply-accumulate with valid
//            tracking, wrap-around accumulator and sticky overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
module dsp_pipelined_mac #(
    parameter int DATA_WIDTH  = 4,
    parameter int PIPE_STAGES = 2,
    parameter int ACC_WIDTH   = 2*DATA_WIDTH+2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  m,
    input  logic                  clr,
    output logic                  out_valid,
    output logic [ACC_WIDTH-1:0]  out,
    output logic                  overflow
);

    localparam int c_PROD_W = 2*DATA_WIDTH;
    localparam int c_MID    = PIPE_STAGES-2;

    // Stage 1: input register
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH-1:0] r_b;
    logic                  r_m;
    logic                  r_clr;
    logic                  r_v;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a   <= '0;
            r_b   <= '0;
            r_m   <= 1'b0;
            r_clr <= 1'b0;
            r_v   <= 1'b0;
        end else begin
            r_a   <= a;
            r_b   <= b;
            r_m   <= m;
            r_clr <= clr;
            r_v   <= in_valid;
        end
    end

    logic [c_PROD_W-1:0] w_p;
    assign w_p = c_PROD_W'(r_a) * c_PROD_W'(r_b);

    // Inputs seen by the final stage, either straight from stage 1 or delayed
    logic [c_PROD_W-1:0] w_fin_p;
    logic                w_fin_m;
    logic                w_fin_clr;
    logic                w_fin_v;

    generate
        if (c_MID == 0) begin : g_no_mid
            assign w_fin_p   = w_p;
            assign w_fin_m   = r_m;
            assign w_fin_clr = r_clr;
            assign w_fin_v   = r_v;
        end else begin : g_mid
            logic [c_PROD_W-1:0] r_p_d [c_MID];
            logic [c_MID-1:0]    r_m_d;
            logic [c_MID-1:0]    r_clr_d;
            logic [c_MID-1:0]    r_v_d;

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < c_MID; i++) begin
                        r_p_d[i] <= '0;
                    end
                    r_m_d   <= '0;
                    r_clr_d <= '0;
                    r_v_d   <= '0;
                end else begin
                    r_p_d[0]   <= w_p;
                    r_m_d[0]   <= r_m;
                    r_clr_d[0] <= r_clr;
                    r_v_d[0]   <= r_v;
                    for (int i = 1; i < c_MID; i++) begin
                        r_p_d[i]   <= r_p_d[i-1];
                        r_m_d[i]   <= r_m_d[i-1];
                        r_clr_d[i] <= r_clr_d[i-1];
                        r_v_d[i]   <= r_v_d[i-1];
                    end
                end
            end

            assign w_fin_p   = r_p_d[c_MID-1];
            assign w_fin_m   = r_m_d[c_MID-1];
            assign w_fin_clr = r_clr_d[c_MID-1];
            assign w_fin_v   = r_v_d[c_MID-1];
        end
    endgenerate

    // Final stage: accumulator feedback closes within this single register
    logic [ACC_WIDTH-1:0] r_acc;
    logic [ACC_WIDTH-1:0] r_out;
    logic                 r_out_valid;
    logic                 r_overflow;
    logic [ACC_WIDTH-1:0] w_p_ext;
    logic [ACC_WIDTH:0]   w_sum;

    assign w_p_ext = ACC_WIDTH'(w_fin_p);
    assign w_sum   = {1'b0, r_acc} + {1'b0, w_p_ext};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc       <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_out_valid <= w_fin_v;
            if (w_fin_v) begin
                if (!w_fin_m) begin
                    r_out <= w_p_ext;
                end else if (w_fin_clr) begin
                    r_acc      <= w_p_ext;
                    r_out      <= w_p_ext;
                    r_overflow <= 1'b0;
                end else begin
                    r_acc <= w_sum[ACC_WIDTH-1:0];
                    r_out <= w_sum[ACC_WIDTH-1:0];
                    if (w_sum[ACC_WIDTH]) begin
                        r_overflow <= 1'b1;
                    end
                end
            end
        end
    end

    assign out       = r_out;
    assign out_valid = r_out_valid;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire
